// File: rtl/apple1_pkg.sv
// Shared constants for the Apple-1 keyboard/display port: register offsets,
// status/overflow bit positions and the FIFO pointer width helper.
package apple1_pkg;

   localparam logic [1:0] REG_KBD   = 2'd0;
   localparam logic [1:0] REG_KBDCR = 2'd1;
   localparam logic [1:0] REG_DSP   = 2'd2;
   localparam logic [1:0] REG_DSPCR = 2'd3;

   localparam int STATUS_BIT = 7;
   localparam int OVF_BIT    = 6;

   // Pointer width for a power-of-two FIFO; depth 2 still needs one bit.
   function automatic int fifo_aw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/apple1_kbd_fifo.sv
// Keystroke FIFO: 7-bit entries, registered count/full/empty, sticky overflow.
// A push into a full FIFO survives only if a pop happens on the same edge.
module apple1_kbd_fifo
   import apple1_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = fifo_aw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [6:0]    push_data,
   input  logic          pop,
   input  logic          ovf_clr,
   output logic [6:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ovf
);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [6:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;
   logic          drop;
   logic [AW:0]   count_next;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next == FULL_COUNT);
         empty <= (count_next == '0);
         // A fresh overflow wins over a clear on the same edge so it is never lost.
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/apple1_pia.sv
// Apple-1 keyboard/display port: 4-register CPU window, keystroke FIFO and a
// valid/ready display output with busy and overflow status.
module apple1_pia
   import apple1_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hD010,  // must be 4-byte aligned
   parameter int          KBD_DEPTH = 4
) (
   input  logic        clk14,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] addr,
   input  logic        we,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        cs,
   input  logic [7:0]  kbd_data,
   input  logic        kbd_strobe,
   output logic        kbd_full,
   output logic [7:0]  dsp_data,
   output logic        dsp_valid,
   input  logic        dsp_ready
);

   localparam int AW = fifo_aw(KBD_DEPTH);

   logic [1:0]  offset;
   logic        rd;
   logic        wr;
   logic        kbd_pop;
   logic        kbd_ovf_clr;
   logic [6:0]  kbd_head;
   logic [AW:0] kbd_count;
   logic        kbd_empty;
   logic        kbd_ovf;
   logic        kbd_nonempty;
   logic [6:0]  last_char;
   logic [5:0]  cr_k;
   logic [5:0]  cr_d;
   logic        dsp_ovf;
   logic [7:0]  rd_data;
   logic        unused_bits;

   assign cs     = (addr[15:2] == BASE_ADDR[15:2]);
   assign offset = addr[1:0];
   assign rd     = enable & cs & ~we;
   assign wr     = enable & cs & we;

   assign kbd_pop      = rd & (offset == REG_KBD) & ~kbd_empty;
   assign kbd_ovf_clr  = rd & (offset == REG_KBDCR);
   assign kbd_nonempty = (kbd_count != '0);

   // Bit 7 of keycodes and display writes is never stored.
   assign unused_bits = ^{din[7], kbd_data[7]};

   apple1_kbd_fifo #(
      .DEPTH (KBD_DEPTH),
      .AW    (AW)
   ) u_kbd_fifo (
      .clk       (clk14),
      .rst       (rst),
      .push      (kbd_strobe),
      .push_data (kbd_data[6:0]),
      .pop       (kbd_pop),
      .ovf_clr   (kbd_ovf_clr),
      .head      (kbd_head),
      .count     (kbd_count),
      .full      (kbd_full),
      .empty     (kbd_empty),
      .ovf       (kbd_ovf)
   );

   always_comb begin
      rd_data = '0;
      case (offset)
         REG_KBD: begin
            rd_data[6:0]       = kbd_empty ? last_char : kbd_head;
            rd_data[STATUS_BIT] = ~kbd_empty;
         end
         REG_KBDCR: begin
            rd_data[5:0]        = cr_k;
            rd_data[OVF_BIT]    = kbd_ovf;
            rd_data[STATUS_BIT] = kbd_nonempty;
         end
         REG_DSP: begin
            rd_data[6:0]        = dsp_data[6:0];
            rd_data[STATUS_BIT] = dsp_valid;
         end
         default: begin
            rd_data[5:0]     = cr_d;
            rd_data[OVF_BIT] = dsp_ovf;
         end
      endcase
   end

   always_ff @(posedge clk14 or posedge rst) begin
      if (rst) begin
         dout      <= 8'h00;
         last_char <= '0;
         cr_k      <= '0;
         cr_d      <= '0;
      end else begin
         if (rd) dout <= rd_data;
         if (kbd_pop) last_char <= kbd_head;
         if (wr && offset == REG_KBDCR) cr_k <= din[5:0];
         if (wr && offset == REG_DSPCR) cr_d <= din[5:0];
      end
   end

   // Display handshake: a character transfers on any edge where dsp_valid and
   // dsp_ready are both high; dsp_data is stable while dsp_valid is high.
   // Busy is the pre-edge dsp_valid, so a write on the transfer edge is dropped.
   always_ff @(posedge clk14 or posedge rst) begin
      if (rst) begin
         dsp_data  <= 8'h00;
         dsp_valid <= 1'b0;
         dsp_ovf   <= 1'b0;
      end else begin
         if (dsp_valid && dsp_ready) dsp_valid <= 1'b0;
         if (wr && offset == REG_DSP) begin
            if (dsp_valid) begin
               dsp_ovf <= 1'b1;
            end else begin
               dsp_data  <= {1'b0, din[6:0]};
               dsp_valid <= 1'b1;
            end
         end
         if (rd && offset == REG_DSPCR) dsp_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_apple1_pia.sv
// Directed bench for apple1_pia: a vector table for the main register/FIFO
// flow plus hand-written sequences for handshake, reset and decode corners.
module tb_apple1_pia;

   // ---------------- clock / reset ----------------
   logic clk14 = 1'b0;
   always #5 clk14 = ~clk14;

   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        we = 1'b0;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;
   logic        cs;
   logic [7:0]  kbd_data = 8'h00;
   logic        kbd_strobe = 1'b0;
   logic        kbd_full;
   logic [7:0]  dsp_data;
   logic        dsp_valid;
   logic        dsp_ready = 1'b0;

   logic        c_enable = 1'b0;
   logic [15:0] c_addr = 16'h0000;
   logic        c_we = 1'b0;
   logic [7:0]  c_din = 8'h00;
   logic [7:0]  c_dout;
   logic        c_cs;
   logic [7:0]  c_kbd_data = 8'h00;
   logic        c_kbd_strobe = 1'b0;
   logic        c_kbd_full;
   logic [7:0]  c_dsp_data;
   logic        c_dsp_valid;
   logic        c_dsp_ready = 1'b0;

   apple1_pia #(.BASE_ADDR(16'hD010), .KBD_DEPTH(4)) dut (
      .clk14(clk14), .rst(rst), .enable(enable), .addr(addr), .we(we),
      .din(din), .dout(dout), .cs(cs), .kbd_data(kbd_data),
      .kbd_strobe(kbd_strobe), .kbd_full(kbd_full), .dsp_data(dsp_data),
      .dsp_valid(dsp_valid), .dsp_ready(dsp_ready)
   );

   apple1_pia #(.BASE_ADDR(16'hC000), .KBD_DEPTH(4)) dut_c (
      .clk14(clk14), .rst(rst), .enable(c_enable), .addr(c_addr), .we(c_we),
      .din(c_din), .dout(c_dout), .cs(c_cs), .kbd_data(c_kbd_data),
      .kbd_strobe(c_kbd_strobe), .kbd_full(c_kbd_full), .dsp_data(c_dsp_data),
      .dsp_valid(c_dsp_valid), .dsp_ready(c_dsp_ready)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk14);
      #1;
   endtask

   task automatic cpu_read(input logic [15:0] a);
      enable = 1'b1; we = 1'b0; addr = a;
      tick();
      enable = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      enable = 1'b1; we = 1'b1; addr = a; din = d;
      tick();
      enable = 1'b0; we = 1'b0;
   endtask

   task automatic push_key(input logic [7:0] k);
      kbd_strobe = 1'b1; kbd_data = k;
      tick();
      kbd_strobe = 1'b0;
   endtask

   task automatic c_read(input logic [15:0] a, input logic en);
      c_enable = en; c_we = 1'b0; c_addr = a;
      tick();
      c_enable = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        en;
      logic [15:0] a;
      logic        w;
      logic [7:0]  d;
      logic        stb;
      logic [7:0]  kd;
      logic [7:0]  exp_dout;
      logic        exp_full;
      logic        exp_valid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic en, input logic [15:0] a, input logic w,
                               input logic [7:0] d, input logic stb, input logic [7:0] kd,
                               input logic [7:0] exp_dout, input logic exp_full,
                               input logic exp_valid);
      vec_t v;
      v.en = en; v.a = a; v.w = w; v.d = d; v.stb = stb; v.kd = kd;
      v.exp_dout = exp_dout; v.exp_full = exp_full; v.exp_valid = exp_valid;
      return v;
   endfunction

   initial begin
      logic [7:0] k;

      //            en  addr      we  din    stb kd     dout   full valid
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'hC1, 8'h00, 0, 0)); // push 'A'
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'hC2, 8'h00, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'hC3, 8'h00, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hC1, 0, 0)); // FIFO order
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hC2, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hC3, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'h43, 0, 0)); // empty: last char
      vecs.push_back(mk(0, 16'hD010, 0, 8'h00, 0, 8'h00, 8'h43, 0, 0)); // no enable: hold
      vecs.push_back(mk(1, 16'hD011, 1, 8'h2A, 0, 8'h00, 8'h43, 0, 0)); // cr_k = 2A
      vecs.push_back(mk(1, 16'hD011, 0, 8'h00, 0, 8'h00, 8'h2A, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'h31, 8'h2A, 0, 0)); // fill to overflow
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'h32, 8'h2A, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'h33, 8'h2A, 0, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'h34, 8'h2A, 1, 0));
      vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 1, 8'h35, 8'h2A, 1, 0)); // dropped
      vecs.push_back(mk(1, 16'hD011, 0, 8'h00, 0, 8'h00, 8'hEA, 1, 0)); // nonempty|ovf|cr_k
      vecs.push_back(mk(1, 16'hD011, 0, 8'h00, 0, 8'h00, 8'hAA, 1, 0)); // ovf cleared
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 1, 8'h36, 8'hB1, 1, 0)); // push+pop when full
      vecs.push_back(mk(1, 16'hD011, 0, 8'h00, 0, 8'h00, 8'hAA, 1, 0)); // no ovf from it
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hB2, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hB3, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hB4, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hB6, 0, 0)); // new key last
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'h36, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 1, 8'h37, 8'h36, 0, 0)); // push+pop when empty
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'hB7, 0, 0));
      vecs.push_back(mk(1, 16'hD010, 0, 8'h00, 0, 8'h00, 8'h37, 0, 0));
      vecs.push_back(mk(1, 16'hD012, 1, 8'h8D, 0, 8'h00, 8'h37, 0, 1)); // display write
      vecs.push_back(mk(1, 16'hD012, 0, 8'h00, 0, 8'h00, 8'h8D, 0, 1));
      vecs.push_back(mk(1, 16'hD012, 1, 8'h41, 0, 8'h00, 8'h8D, 0, 1)); // busy: dropped
      vecs.push_back(mk(1, 16'hD013, 0, 8'h00, 0, 8'h00, 8'h40, 0, 1));
      vecs.push_back(mk(1, 16'hD013, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1));

      // Reset state.
      tick(); tick(); tick();
      chk("reset_dout", dout, 8'h00);
      chk("reset_full", {7'd0, kbd_full}, 8'h00);
      chk("reset_valid", {7'd0, dsp_valid}, 8'h00);
      chk("reset_dsp_data", dsp_data, 8'h00);
      rst = 1'b0;
      tick();

      // Table-driven main flow.
      for (int i = 0; i < vecs.size(); i++) begin
         enable = vecs[i].en; addr = vecs[i].a; we = vecs[i].w; din = vecs[i].d;
         kbd_strobe = vecs[i].stb; kbd_data = vecs[i].kd;
         tick();
         enable = 1'b0; we = 1'b0; kbd_strobe = 1'b0;
         chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
         chk($sformatf("v%0d_full", i), {7'd0, kbd_full}, {7'd0, vecs[i].exp_full});
         chk($sformatf("v%0d_valid", i), {7'd0, dsp_valid}, {7'd0, vecs[i].exp_valid});
      end

      // Display handshake completion.
      chk("dsp_data_0d", dsp_data, 8'h0D);
      dsp_ready = 1'b1;
      tick();
      dsp_ready = 1'b0;
      chk("dsp_valid_fall", {7'd0, dsp_valid}, 8'h00);

      // Write on the transfer edge is dropped and flagged.
      cpu_write(16'hD012, 8'h55);
      chk("dsp_valid_55", {7'd0, dsp_valid}, 8'h01);
      dsp_ready = 1'b1;
      cpu_write(16'hD012, 8'h66);
      dsp_ready = 1'b0;
      chk("hs_edge_valid", {7'd0, dsp_valid}, 8'h00);
      chk("hs_edge_data", dsp_data, 8'h55);
      cpu_read(16'hD013);
      chk("hs_edge_ovf", dout, 8'h40);

      // Scoreboard burst with arbitrary keys (bit 7 must be ignored).
      for (int i = 0; i < 4; i++) begin
         k = 8'($urandom_range(0, 255));
         push_key(k);
         exp_q.push_back({1'b1, k[6:0]});
      end
      chk("burst_full", {7'd0, kbd_full}, 8'h01);
      while (exp_q.size() > 0) begin
         cpu_read(16'hD010);
         chk("burst_pop", dout, exp_q.pop_front());
      end

      // Reset mid-operation.
      push_key(8'hC1); push_key(8'hC2); push_key(8'hC3);
      cpu_write(16'hD012, 8'h2E);
      cpu_write(16'hD011, 8'h15);
      cpu_read(16'hD011);
      chk("pre_rst_kbdcr", dout, 8'h95);
      chk("pre_rst_valid", {7'd0, dsp_valid}, 8'h01);
      rst = 1'b1;
      #1;
      chk("mid_rst_dout", dout, 8'h00);
      chk("mid_rst_valid", {7'd0, dsp_valid}, 8'h00);
      chk("mid_rst_full", {7'd0, kbd_full}, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      cpu_read(16'hD011);
      chk("post_rst_kbdcr", dout, 8'h00);
      cpu_read(16'hD010);
      chk("post_rst_kbd", dout, 8'h00);

      // Decode with BASE_ADDR = C000.
      c_addr = 16'hD010;
      #1;
      chk("c_cs_d010", {7'd0, c_cs}, 8'h00);
      addr = 16'hD013;
      #1;
      chk("cs_d013", {7'd0, cs}, 8'h01);
      addr = 16'hD014;
      #1;
      chk("cs_d014", {7'd0, cs}, 8'h00);
      c_kbd_strobe = 1'b1; c_kbd_data = 8'h5A;
      tick();
      c_kbd_strobe = 1'b0;
      c_read(16'hD010, 1'b1);
      chk("c_d010_no_effect", c_dout, 8'h00);
      c_enable = 1'b1; c_we = 1'b1; c_addr = 16'hC001; c_din = 8'h3F;
      tick();
      c_enable = 1'b0; c_we = 1'b0;
      chk("c_cs_c001", {7'd0, c_cs}, 8'h01);
      c_read(16'hC001, 1'b1);
      chk("c_kbdcr", c_dout, 8'hBF);
      c_read(16'hC000, 1'b0);
      chk("c_noen_hold", c_dout, 8'hBF);
      c_read(16'hC000, 1'b1);
      chk("c_kbd_not_popped", c_dout, 8'hDA);
      c_read(16'hC000, 1'b1);
      chk("c_kbd_empty", c_dout, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
